brq_imem_responder: RTL

//  Responder (slave) end of the core instruction-fetch bus: accepts req/addr from the fetch unit,

---
 rtl/brq_pkg.sv | 16 +
 rtl/brq_imem_responder_if.sv | 17 +
 rtl/brq_imem_resp_pipe.sv | 35 +++
 rtl/brq_imem_responder.sv | 114 +++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types and limits for the brq instruction-fetch responder.
//   imem_rsp_t                 : one response beat {valid, err, rdata}
//   IMEM_MAX_OUTSTANDING_LIMIT : upper bound on granted-but-unanswered requests
//   IMEM_CNT_W                 : width of the outstanding counter
package brq_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } imem_rsp_t;

  localparam int unsigned IMEM_MAX_OUTSTANDING_LIMIT = 4;
  localparam int unsigned IMEM_CNT_W = $clog2(IMEM_MAX_OUTSTANDING_LIMIT + 1);

endpackage

// File: rtl/brq_imem_responder_if.sv
// Instruction-fetch bus between the core fetch unit (master) and a responder (slave).
//   req/addr   : fetch request and byte address (master -> slave)
//   gnt        : request accepted this cycle (slave -> master)
//   rvalid/rdata/err : in-order response beat (slave -> master)
interface brq_imem_responder_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, output addr, input gnt, input rvalid, input rdata, input err);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata, output err);

endinterface

// File: rtl/brq_imem_resp_pipe.sv
// Fixed-depth shift line of response beats that adds Depth cycles of latency.
//   clk_i  : clock
//   rst_i  : synchronous active-high flush of every stage
//   rsp_i  : beat entering the line
//   rsp_o  : beat leaving the line, Depth cycles later
module brq_imem_resp_pipe
  import brq_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  imem_rsp_t rsp_i,
  output imem_rsp_t rsp_o
);

  imem_rsp_t stage_q [Depth];

  // Shift line; reset drops every in-flight beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[Depth-1];

endmodule

// File: rtl/brq_imem_responder.sv
// Slave end of the core instruction-fetch bus backed by a 1-cycle single-port SRAM.
// Grants requests up to MaxOutstanding in flight, answers in order after
// 1+ExtraLatency cycles, and flags addresses outside the RAM window as bus errors.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   instr_bus      : fetch bus, slave side (req/addr in; gnt/rvalid/rdata/err out)
//   gnt_stall_i    : holds off grants while high
//   mem_req_o      : SRAM read enable
//   mem_addr_o     : SRAM word index
//   mem_rdata_i    : SRAM read data, valid the cycle after mem_req_o
//   busy_o         : at least one request outstanding
module brq_imem_responder
  import brq_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0008_0000,
  parameter int unsigned MemSizeBytes   = 4096,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned ExtraLatency   = 0,
  localparam int unsigned AW            = $clog2(MemSizeBytes / 4)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  brq_imem_responder_if.slave   instr_bus,
  input  logic                  gnt_stall_i,
  output logic                  mem_req_o,
  output logic [AW-1:0]         mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  s0_valid_q, s0_err_q;
  logic [31:0]           offset;
  logic                  in_range;
  logic                  gnt;
  imem_rsp_t             s0_rsp;
  imem_rsp_t             out_rsp;

  // Window check; the >= term stops a wrapped subtraction from looking in range
  assign offset   = instr_bus.addr - BaseAddr;
  assign in_range = (instr_bus.addr >= BaseAddr) && (offset < 32'(MemSizeBytes));

  // A response retiring this cycle frees its slot for a same-cycle grant
  assign gnt = instr_bus.req & ~gnt_stall_i & ~rst_i &
               ((cnt_q < IMEM_CNT_W'(MaxOutstanding)) | out_rsp.valid);

  assign mem_req_o  = gnt & in_range;
  assign mem_addr_o = offset[AW+1:2];

  // Stage 0: remember that a grant happened and whether it missed the window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
    end else begin
      s0_valid_q <= gnt;
      s0_err_q   <= gnt & ~in_range;
    end
  end

  // SRAM data lands the cycle after the read; errored or idle beats carry zero
  always_comb begin
    s0_rsp       = '0;
    s0_rsp.valid = s0_valid_q;
    s0_rsp.err   = s0_err_q;
    s0_rsp.rdata = (s0_valid_q & ~s0_err_q) ? mem_rdata_i : 32'h0;
  end

  if (ExtraLatency == 0) begin : g_direct
    assign out_rsp = s0_rsp;
  end else begin : g_pipe
    brq_imem_resp_pipe #(
      .Depth (ExtraLatency)
    ) u_resp_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rsp_i (s0_rsp),
      .rsp_o (out_rsp)
    );
  end

  // Outstanding count: +1 per grant, -1 per response
  always_comb begin
    cnt_d = cnt_q;
    case ({gnt, out_rsp.valid})
      2'b10:   cnt_d = cnt_q + IMEM_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - IMEM_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_bus.gnt    = gnt;
  assign instr_bus.rvalid = out_rsp.valid;
  assign instr_bus.rdata  = out_rsp.rdata;
  assign instr_bus.err    = out_rsp.err;
  assign busy_o           = (cnt_q != '0);

  // Bookkeeping invariants
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (cnt_q <= IMEM_CNT_W'(MaxOutstanding));
      assert (!out_rsp.valid || (cnt_q != '0));
      assert (!gnt || instr_bus.req);
    end
  end

endmodule
